// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } fetch_state_t;

  localparam logic BUS_READ  = 1'b1;
  localparam logic BUS_WRITE = 1'b0;

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding fetched bytes with their source address.
// The storage is cleared on reset so the head reads as zero afterwards.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_entry,
  output fetch_entry_t head,
  output logic         valid,
  output logic [CW-1:0] count
);

  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  // Pointer, occupancy and storage update; flush wins over push/pop.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign valid = (count != '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: runs two-phase read cycles on the shared
// multiplexed bus and feeds the decoder from a prefetch FIFO.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int         DEPTH    = 2,
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       enable,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  input  logic [7:0] bus_in,
  output logic       ale,
  output logic       rw,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic [7:0] out_pc,
  input  logic       out_ready,
  input  logic       redirect_valid,
  input  logic [7:0] redirect_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t  state;
  fetch_state_t  state_next;
  logic [7:0]    pc;
  logic          discard;
  logic          push;
  logic          pop;
  logic [CW-1:0] count;
  logic [CW-1:0] count_after;
  fetch_entry_t  wr_entry;
  fetch_entry_t  head;

  // A byte whose read was overtaken by a redirect is dropped at the data edge.
  assign push        = (state == DATA) && !discard && !redirect_valid;
  assign pop         = out_valid && out_ready && !redirect_valid;
  assign count_after = count + CW'(push) - CW'(pop);
  assign wr_entry    = '{data: bus_in, pc: pc};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK      (CLK),
    .RST      (RST),
    .push     (push),
    .pop      (pop),
    .flush    (redirect_valid),
    .wr_entry (wr_entry),
    .head     (head),
    .valid    (out_valid),
    .count    (count)
  );

  // Next-state: a read only starts when a FIFO slot is guaranteed free.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (enable && (redirect_valid || count < CW'(DEPTH))) state_next = ADDR;
      ADDR: state_next = DATA;
      DATA: begin
        if (redirect_valid || (enable && count_after < CW'(DEPTH))) state_next = ADDR;
        else state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, program counter and discard flag registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      discard <= 1'b0;
    end else begin
      state <= state_next;
      if (redirect_valid) pc <= redirect_pc;
      else if (state == DATA && !discard) pc <= pc + 8'd1;
      // Address already latched by memory: the coming data phase is stale.
      discard <= (state == ADDR) && redirect_valid;
    end
  end

  assign bus_oe   = (state == ADDR);
  assign ale      = (state == ADDR);
  assign bus_out  = (state == ADDR) ? pc : 8'h00;
  assign rw       = BUS_READ;
  assign out_data = head.data;
  assign out_pc   = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory model on the bus, in-order stream model
// for the decoder side, and directed scenarios with literal expectations.
module tb_fetch_unit;

  logic       CLK;
  logic       RST;
  logic       enable;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic [7:0] bus_in;
  logic       ale;
  logic       rw;
  logic       out_valid;
  logic [7:0] out_data;
  logic [7:0] out_pc;
  logic       out_ready;
  logic       redirect_valid;
  logic [7:0] redirect_pc;

  int n_checks = 0;
  int n_fail   = 0;
  int n_stream = 0;
  int ale_cnt  = 0;

  fetch_unit #(.DEPTH(2), .RESET_PC(8'h00)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .enable         (enable),
    .bus_out        (bus_out),
    .bus_oe         (bus_oe),
    .bus_in         (bus_in),
    .ale            (ale),
    .rw             (rw),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_pc         (out_pc),
    .out_ready      (out_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory: latches the address on an ale edge and drives data otherwise.
  logic [7:0] mem [256];
  logic [7:0] addr_lat = 8'h00;
  always @(posedge CLK) if (ale) addr_lat <= bus_out;
  assign bus_in = bus_oe ? bus_out : mem[addr_lat];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stream model: the decoder must see mem[p], mem[p+1], ... in order,
  // where p restarts at the reset PC or at each redirect target.
  logic [7:0] exp_pc;
  always @(posedge CLK or negedge RST) begin
    if (!RST) exp_pc <= 8'h00;
    else if (redirect_valid) exp_pc <= redirect_pc;
    else if (out_valid && out_ready) exp_pc <= exp_pc + 8'd1;
  end

  // Per-cycle comparison against the stream model and bus invariants.
  always @(negedge CLK) begin
    chk("rw_read", rw, 1);
    chk("oe_eq_ale", bus_oe, ale);
    if (ale) ale_cnt++;
    if (RST && out_valid) begin
      n_stream++;
      chk("stream_data", out_data, mem[exp_pc]);
      chk("stream_pc", out_pc, exp_pc);
    end
  end

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    #2;
    RST            = 1'b0;
    enable         = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    @(negedge CLK);
    RST = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i + 8'h10);
    mem[8'hFF] = 8'hAA;
    RST = 1'b0; enable = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 8'h00;

    // Reset state
    #3;
    chk("rst_bus_oe", bus_oe, 0);
    chk("rst_ale", ale, 0);
    chk("rst_bus_out", bus_out, 8'h00);
    chk("rst_rw", rw, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_out_pc", out_pc, 8'h00);

    // 1. Basic fetch
    @(negedge CLK);
    RST = 1'b1; enable = 1'b1; out_ready = 1'b1;
    tick();
    chk("t1_e1_ale", ale, 1); chk("t1_e1_addr", bus_out, 8'h00); chk("t1_e1_valid", out_valid, 0);
    tick();
    chk("t1_e2_oe", bus_oe, 0); chk("t1_e2_valid", out_valid, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t1_valid", out_valid, 1);
      chk("t1_data", out_data, 32'h10 + k);
      chk("t1_pc", out_pc, k);
      chk("t1_next_addr", bus_out, k + 1);
      tick();
      chk("t1_gap", out_valid, 0);
    end

    // 2. Backpressure
    do_reset();
    enable = 1'b1; out_ready = 1'b0;
    base = ale_cnt;
    tick(); tick(); tick();
    chk("t2_e3_addr", bus_out, 8'h01);
    tick(); tick();
    chk("t2_idle_oe", bus_oe, 0);
    chk("t2_head", out_data, 8'h10);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t2_hold_oe", bus_oe, 0);
      chk("t2_hold_head", out_data, 8'h10);
    end
    chk("t2_reads", ale_cnt - base, 2);
    out_ready = 1'b1;
    tick();
    chk("t2_second", out_data, 8'h11); chk("t2_second_pc", out_pc, 8'h01);
    tick();
    chk("t2_resume_ale", ale, 1); chk("t2_resume_addr", bus_out, 8'h02);
    tick(); tick();
    chk("t2_third", out_data, 8'h12); chk("t2_third_valid", out_valid, 1);

    // 3. Redirect during DATA
    do_reset();
    enable = 1'b1; out_ready = 1'b1;
    tick(); tick();
    redirect_valid = 1'b1; redirect_pc = 8'h02;
    tick();
    redirect_valid = 1'b0;
    chk("t3_no_byte", out_valid, 0);
    chk("t3_ale", ale, 1); chk("t3_addr", bus_out, 8'h02);
    tick(); tick();
    chk("t3_data0", out_data, 8'h12); chk("t3_pc0", out_pc, 8'h02);
    tick(); tick();
    chk("t3_data1", out_data, 8'h13); chk("t3_pc1", out_pc, 8'h03);

    // 4. Redirect with simultaneous pop on a full FIFO
    do_reset();
    enable = 1'b1; out_ready = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    chk("t4_full_valid", out_valid, 1); chk("t4_full_idle", bus_oe, 0);
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'h00;
    tick();
    redirect_valid = 1'b0;
    chk("t4_flushed", out_valid, 0);
    chk("t4_ale", ale, 1); chk("t4_addr", bus_out, 8'h00);
    tick(); tick();
    chk("t4_refetch", out_data, 8'h10); chk("t4_refetch_pc", out_pc, 8'h00);

    // 5. PC wrap
    do_reset();
    enable = 1'b1; out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'hFF;
    tick();
    redirect_valid = 1'b0;
    chk("t5_addr_ff", bus_out, 8'hFF);
    tick(); tick();
    chk("t5_data_ff", out_data, 8'hAA); chk("t5_pc_ff", out_pc, 8'hFF);
    chk("t5_wrap_addr", bus_out, 8'h00);
    tick(); tick();
    chk("t5_data_00", out_data, 8'h10); chk("t5_pc_00", out_pc, 8'h00);

    // 6. Mid-cycle reset during DATA
    do_reset();
    enable = 1'b1; out_ready = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("t6_pre_valid", out_valid, 1);
    #3;
    RST = 1'b0;
    #1;
    chk("t6_async_oe", bus_oe, 0);
    chk("t6_async_ale", ale, 0);
    chk("t6_async_valid", out_valid, 0);
    chk("t6_async_data", out_data, 8'h00);
    chk("t6_async_bus", bus_out, 8'h00);
    @(negedge CLK);
    RST = 1'b1; out_ready = 1'b1;
    tick();
    chk("t6_restart_ale", ale, 1); chk("t6_restart_addr", bus_out, 8'h00);
    tick(); tick();
    chk("t6_data", out_data, 8'h10); chk("t6_pc", out_pc, 8'h00);

    chk("stream_active", (n_stream >= 10), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
